if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 21 ++
 rtl/if_skid_buf.sv | 34 +++
 rtl/if_fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_fetch_stage_pkg;

   localparam int unsigned FETCH_ADDR_W = 32;
   localparam int unsigned FETCH_DATA_W = 32;

   localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEF = 32'h1c00_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer parking a fetched instruction while IF/ID is stalled.
module if_skid_buf
   import if_fetch_stage_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_drain,
   input  logic         i_flush,
   input  fetch_entry_t i_entry,
   output logic         o_valid,
   output fetch_entry_t o_entry
);

   logic         r_valid;
   fetch_entry_t r_entry;

   // Flush wins over load so a redirect never leaves a stale entry behind.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_valid <= 1'b0;
         r_entry <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_entry <= i_entry;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_entry = r_entry;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, output slot and skid buffer.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
   parameter int unsigned       DATA_W   = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_branch_en,
   input  logic [ADDR_W-1:0] i_branch_addr,
   input  logic              i_jump_en,
   input  logic [ADDR_W-1:0] i_jump_addr,
   input  logic              i_stall,
   output logic              o_inst_req,
   output logic [ADDR_W-1:0] o_inst_addr,
   input  logic              i_inst_addr_ok,
   input  logic              i_inst_rvalid,
   input  logic [DATA_W-1:0] i_inst_rdata,
   output logic              o_if_valid,
   output logic [ADDR_W-1:0] o_if_pc,
   output logic [DATA_W-1:0] o_if_inst
);

   fetch_state_e      r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
   logic              r_drop, w_drop_nxt;
   logic              r_if_valid, w_if_valid_nxt;
   fetch_entry_t      r_slot, w_slot_nxt;

   logic              w_redirect;
   logic [ADDR_W-1:0] w_target;
   logic              w_slot_free;
   fetch_entry_t      w_resp_entry;

   logic              w_skid_load;
   logic              w_skid_drain;
   logic              w_skid_flush;
   logic              w_skid_valid;
   fetch_entry_t      w_skid_entry;

   assign w_redirect   = i_jump_en | i_branch_en;
   assign w_target     = i_jump_en ? i_jump_addr : i_branch_addr;
   assign w_slot_free  = !r_if_valid || !i_stall;
   assign w_resp_entry = '{pc: r_fetch_pc, inst: i_inst_rdata};

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_fetch_pc_nxt = r_fetch_pc;
      w_drop_nxt     = r_drop;
      // An unstalled slot empties at the edge unless reloaded below.
      w_if_valid_nxt = r_if_valid & i_stall;
      w_slot_nxt     = r_slot;
      w_skid_load    = 1'b0;
      w_skid_drain   = 1'b0;
      w_skid_flush   = 1'b0;

      case (r_state)
         S_IDLE: w_state_nxt = S_REQ;
         S_REQ: begin
            if (i_inst_addr_ok) begin
               w_fetch_pc_nxt = r_pc;
               w_pc_nxt       = r_pc + ADDR_W'(4);
               w_state_nxt    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_inst_rvalid) begin
               if (r_drop) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
               end else if (w_slot_free) begin
                  w_slot_nxt     = w_resp_entry;
                  w_if_valid_nxt = 1'b1;
                  w_state_nxt    = S_REQ;
               end else begin
                  w_skid_load = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!i_stall && w_skid_valid) begin
               w_slot_nxt     = w_skid_entry;
               w_if_valid_nxt = 1'b1;
               w_skid_drain   = 1'b1;
               w_state_nxt    = S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Redirect overrides stall, consumption and any pending slot/skid load.
      if (w_redirect && (r_state != S_IDLE)) begin
         w_pc_nxt       = w_target;
         w_if_valid_nxt = 1'b0;
         w_slot_nxt     = r_slot;
         w_skid_load    = 1'b0;
         w_skid_drain   = 1'b0;
         w_skid_flush   = 1'b1;
         case (r_state)
            S_REQ: begin
               if (i_inst_addr_ok) begin
                  w_drop_nxt  = 1'b1;
                  w_state_nxt = S_WAIT;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            S_WAIT: begin
               if (i_inst_rvalid) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
               end else begin
                  w_drop_nxt  = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
            S_HOLD:  w_state_nxt = S_REQ;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_fetch_pc <= '0;
         r_drop     <= 1'b0;
         r_if_valid <= 1'b0;
         r_slot     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_drop     <= w_drop_nxt;
         r_if_valid <= w_if_valid_nxt;
         r_slot     <= w_slot_nxt;
      end
   end

   if_skid_buf u_skid (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_skid_load),
      .i_drain (w_skid_drain),
      .i_flush (w_skid_flush),
      .i_entry (w_resp_entry),
      .o_valid (w_skid_valid),
      .o_entry (w_skid_entry)
   );

   assign o_inst_req  = (r_state == S_REQ);
   assign o_inst_addr = r_pc;
   assign o_if_valid  = r_if_valid;
   assign o_if_pc     = r_slot.pc;
   assign o_if_inst   = r_slot.inst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then random traffic
// against a queue-based model of the instruction stream.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h1c00_0000;

   logic        clk = 1'b0;
   logic        rst, branch_en, jump_en, stall;
   logic [31:0] branch_addr, jump_addr;
   logic        inst_req, inst_addr_ok, inst_rvalid;
   logic [31:0] inst_addr, inst_rdata;
   logic        if_valid;
   logic [31:0] if_pc, if_inst;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_branch_en    (branch_en),
      .i_branch_addr  (branch_addr),
      .i_jump_en      (jump_en),
      .i_jump_addr    (jump_addr),
      .i_stall        (stall),
      .o_inst_req     (inst_req),
      .o_inst_addr    (inst_addr),
      .i_inst_addr_ok (inst_addr_ok),
      .i_inst_rvalid  (inst_rvalid),
      .i_inst_rdata   (inst_rdata),
      .o_if_valid     (if_valid),
      .o_if_pc        (if_pc),
      .o_if_inst      (if_inst)
   );

   int n_checks = 0;
   int n_errs   = 0;

   // Stimulus knobs applied by step() at the start of each cycle.
   logic        s_rst = 1'b1, s_stall = 1'b0, s_jump = 1'b0, s_branch = 1'b0;
   logic [31:0] s_jaddr = '0, s_baddr = '0;
   int          acc_pct = 100, lat_min = 1, lat_max = 1;

   // Memory: one outstanding request, fixed contents derived from the address.
   bit          m_pend = 1'b0;
   int          m_cnt  = 0;
   logic [31:0] m_addr = '0;

   // Model: expected PC register, and the ordered list of live instructions (slot first).
   logic [63:0] q[$];
   logic [31:0] exp_pc = RST_PC;
   bit          m_idle = 1'b1;
   bit          m_killed = 1'b0;
   logic [31:0] m_req_pc = '0;
   int          n_delivered = 0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h1c00_0000) return 32'h0280_0000;
      return {a[15:0], a[31:16]} ^ 32'h9e37_79b9;
   endfunction

   function automatic logic [31:0] rand_target();
      case ($urandom_range(3))
         0:       return {16'h1c00, 16'($urandom()) & 16'hfffc};
         1:       return 32'hffff_fff0 | ($urandom() & 32'hc);
         2:       return $urandom();
         default: return $urandom() & 32'hffff_fffc;
      endcase
   endfunction

   task automatic chkb(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Advance one cycle: drive inputs, check outputs against the model, update the model.
   task automatic step();
      logic        redir, acc, resp, cons;
      logic [31:0] tgt;
      @(posedge clk);
      #1;
      resp = 1'b0;
      if (m_pend) begin
         m_cnt--;
         resp = (m_cnt == 0);
      end
      rst         = s_rst;
      stall       = s_stall;
      jump_en     = s_jump;
      jump_addr   = s_jaddr;
      branch_en   = s_branch;
      branch_addr = s_baddr;
      inst_rvalid = resp;
      inst_rdata  = resp ? mem_data(m_addr) : $urandom();
      acc = inst_req && !m_pend && ($urandom_range(99) < acc_pct);
      inst_addr_ok = acc;

      if (m_idle) chkb("idle_no_req", inst_req, 1'b0);
      if (inst_req) chk32("req_addr", inst_addr, exp_pc);
      if (m_pend) chkb("one_outstanding", inst_req, 1'b0);
      chkb("if_valid", if_valid, q.size() > 0);
      if (if_valid && q.size() > 0) begin
         chk32("slot_pc", if_pc, q[0][63:32]);
         chk32("slot_inst", if_inst, q[0][31:0]);
      end

      redir = (s_jump || s_branch) && !m_idle && !s_rst;
      tgt   = s_jump ? s_jaddr : s_baddr;
      cons  = (q.size() > 0) && !s_stall;
      if (s_rst) begin
         q.delete();
         exp_pc   = RST_PC;
         m_idle   = 1'b1;
         m_pend   = 1'b0;
         m_killed = 1'b0;
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else begin
         if (acc) begin
            m_pend   = 1'b1;
            m_addr   = inst_addr;
            m_cnt    = $urandom_range(lat_max, lat_min);
            m_req_pc = exp_pc;
            m_killed = 1'b0;
            exp_pc   = exp_pc + 32'd4;
         end
         if (resp) m_pend = 1'b0;
         if (redir) begin
            q.delete();
            m_killed = 1'b1;
            exp_pc   = tgt;
         end else begin
            if (cons) begin
               void'(q.pop_front());
               n_delivered++;
            end
            if (resp && !m_killed) q.push_back({m_req_pc, mem_data(m_req_pc)});
         end
      end
   endtask

   initial begin
      int start;
      rst = 1'b1; stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
      jump_addr = '0; branch_addr = '0;
      inst_addr_ok = 1'b0; inst_rvalid = 1'b0; inst_rdata = '0;

      // Reset release and first fetch.
      s_rst = 1'b1; step(); step();
      s_rst = 1'b0; step();                                   // cycle 0
      chkb("c0_req", inst_req, 1'b0);
      chkb("c0_valid", if_valid, 1'b0);
      chk32("c0_if_pc", if_pc, 32'h0);
      chk32("c0_if_inst", if_inst, 32'h0);
      chk32("c0_addr", inst_addr, 32'h1c00_0000);
      step();                                                 // cycle 1
      chkb("c1_req", inst_req, 1'b1);
      chk32("c1_addr", inst_addr, 32'h1c00_0000);
      step();                                                 // cycle 2
      s_stall = 1'b1; step();                                 // cycle 3
      chkb("c3_valid", if_valid, 1'b1);
      chk32("c3_if_pc", if_pc, 32'h1c00_0000);
      chk32("c3_if_inst", if_inst, 32'h0280_0000);
      chk32("c3_addr", inst_addr, 32'h1c00_0004);

      // Stall parks the second response in the skid buffer.
      step(); step();                                         // cycles 4,5
      chk32("c5_hold_pc", if_pc, 32'h1c00_0000);
      s_stall = 1'b0; step();                                 // cycle 6
      s_stall = 1'b1; lat_min = 2; lat_max = 2; step();       // cycle 7
      chk32("c7_if_pc", if_pc, 32'h1c00_0004);
      chk32("c7_addr", inst_addr, 32'h1c00_0008);

      // Jump while waiting: in-flight response dropped.
      s_jump = 1'b1; s_jaddr = 32'h1c00_0100; step();         // cycle 8
      s_jump = 1'b0; s_stall = 1'b0; lat_min = 1; lat_max = 1;
      step();                                                 // cycle 9
      chkb("c9_flushed", if_valid, 1'b0);
      chkb("c9_no_req", inst_req, 1'b0);
      step();                                                 // cycle 10
      chkb("c10_req", inst_req, 1'b1);
      chk32("c10_addr", inst_addr, 32'h1c00_0100);
      chkb("c10_valid", if_valid, 1'b0);
      step();                                                 // cycle 11

      // Jump beats branch.
      s_jump = 1'b1; s_jaddr = 32'h100; s_branch = 1'b1; s_baddr = 32'h200;
      step();                                                 // cycle 12
      chk32("c12_if_pc", if_pc, 32'h1c00_0100);
      s_jump = 1'b0; s_branch = 1'b0; step();                 // cycle 13
      chkb("c13_valid", if_valid, 1'b0);
      step();                                                 // cycle 14
      chk32("c14_jump_prio", inst_addr, 32'h100);

      // Redirect coincident with response.
      s_branch = 1'b1; s_baddr = 32'h300; step();             // cycle 15
      s_branch = 1'b0; step();                                // cycle 16
      chkb("c16_valid", if_valid, 1'b0);
      chk32("c16_addr", inst_addr, 32'h300);
      step();                                                 // cycle 17

      // Redirect in HOLD under stall.
      s_stall = 1'b1; step();                                 // cycle 18
      chk32("c18_if_pc", if_pc, 32'h300);
      step();                                                 // cycle 19
      s_jump = 1'b1; s_jaddr = 32'h400; step();               // cycle 20
      chkb("c20_valid", if_valid, 1'b1);
      s_jump = 1'b1; s_jaddr = 32'hffff_fffc; s_stall = 1'b0; acc_pct = 0;
      step();                                                 // cycle 21
      chkb("c21_valid", if_valid, 1'b0);
      chk32("c21_addr", inst_addr, 32'h400);

      // Withdrawn request, then PC wrap.
      s_jump = 1'b0; acc_pct = 100; step();                   // cycle 22
      chk32("c22_addr", inst_addr, 32'hffff_fffc);
      step();                                                 // cycle 23
      lat_min = 2; lat_max = 2; step();                       // cycle 24
      chk32("c24_wrap", inst_addr, 32'h0000_0000);
      chk32("c24_if_pc", if_pc, 32'hffff_fffc);

      // Reset during WAIT.
      s_rst = 1'b1; step();                                   // cycle 25
      s_rst = 1'b0; lat_min = 1; lat_max = 1; step();         // cycle 26
      chkb("rst2_req", inst_req, 1'b0);
      chkb("rst2_valid", if_valid, 1'b0);
      chk32("rst2_if_pc", if_pc, 32'h0);
      chk32("rst2_if_inst", if_inst, 32'h0);
      step();                                                 // cycle 27
      chk32("rst2_refetch", inst_addr, RST_PC);

      // Random traffic.
      acc_pct = 70; lat_min = 1; lat_max = 3;
      start = n_delivered;
      for (int i = 0; i < 4000; i++) begin
         int r;
         r        = int'($urandom_range(99));
         s_rst    = ($urandom_range(499) == 0);
         s_stall  = ($urandom_range(99) < 35);
         s_jump   = (r < 4);
         s_branch = (r >= 2 && r < 7);
         s_jaddr  = rand_target();
         s_baddr  = rand_target();
         step();
      end
      chkb("progress", (n_delivered - start) >= 300, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
